// File: rtl/output_reader_6bit_pkg.sv
// Shared constants for the 8x8 output buffer read-back path.
// Lane k of the address controllers always targets column 7-k.
package output_reader_6bit_pkg;

  localparam int N_LANE = 8;
  localparam int ROW_W  = 3;
  localparam int COL_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic logic [COL_W-1:0] col(input int k);
    return COL_W'(N_LANE - 1 - k);
  endfunction

endpackage

// File: rtl/output_reader_6bit_skid.sv
// Two-entry skid FIFO of {row index, full row}.
// Head entry is presented combinationally on head_*_o.
module row_skid_fifo
  import output_reader_6bit_pkg::*;
#(
  parameter int DATA_BW = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  logic [ROW_W-1:0]          push_idx_i,
  input  logic [N_LANE*DATA_BW-1:0] push_row_i,
  input  logic                      pop_i,
  output logic [ROW_W-1:0]          head_idx_o,
  output logic [N_LANE*DATA_BW-1:0] head_row_o,
  output logic [1:0]                count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  logic [ROW_W-1:0]          idx_q [2];
  logic [N_LANE*DATA_BW-1:0] row_q [2];
  logic                      wr_ptr_q;
  logic                      rd_ptr_q;
  logic [1:0]                cnt_q;
  logic [1:0]                cnt_d;

  always_comb begin
    cnt_d = cnt_q + 2'(push_i) - 2'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        idx_q[i] <= '0;
        row_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        idx_q[wr_ptr_q] <= push_idx_i;
        row_q[wr_ptr_q] <= push_row_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign head_idx_o = idx_q[rd_ptr_q];
  assign head_row_o = row_q[rd_ptr_q];
  assign count_o    = cnt_q;
  assign full_o     = (cnt_q == 2'd2);
  assign empty_o    = (cnt_q == 2'd0);

endmodule

// File: rtl/output_reader_6bit.sv
// Drains the diagonally-filled 8x8 output buffer in row-major order
// and streams whole rows out through a 2-entry skid FIFO.
module output_reader_6bit
  import output_reader_6bit_pkg::*;
#(
  parameter int DATA_BW   = 8,
  parameter int ADDR_SIZE = 6
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  output logic                        busy,
  output logic                        rd_en,
  output logic [ADDR_SIZE*N_LANE-1:0] rd_addr_6bit,
  input  logic [N_LANE*DATA_BW-1:0]   rd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_LANE*DATA_BW-1:0]   out_row,
  output logic [ROW_W-1:0]            out_row_idx,
  output logic                        out_last,
  output logic                        done
);

  state_e                    state_q;
  state_e                    state_d;
  logic [ROW_W-1:0]          rd_row_q;
  logic [ROW_W-1:0]          rd_row_d;
  logic                      inflight_q;
  logic [ROW_W-1:0]          infl_row_q;
  logic [N_LANE*DATA_BW-1:0] cap_row;
  logic [1:0]                fifo_cnt;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;
  logic                      issue;
  logic [2:0]                occ;
  logic [2:0]                room;

  assign pop  = out_valid && out_ready;
  assign occ  = 3'(fifo_cnt) + 3'(inflight_q);
  assign room = 3'd2 + 3'(pop);

  // Never let buffered plus in-flight rows exceed the FIFO depth.
  assign issue = (state_q == READ) && (occ < room);

  assign rd_en = issue;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DRAIN) && pop
              && (out_row_idx == ROW_W'(N_LANE - 1));

  always_comb begin
    rd_addr_6bit = '0;
    for (int k = 0; k < N_LANE; k++) begin
      rd_addr_6bit[ADDR_SIZE*k +: ADDR_SIZE] =
        ADDR_SIZE'({rd_row_q, col(k)});
    end
  end

  // Lane k carries column 7-k; put each element in its column slot.
  always_comb begin
    cap_row = '0;
    for (int k = 0; k < N_LANE; k++) begin
      cap_row[DATA_BW*int'(col(k)) +: DATA_BW] =
        rd_data[DATA_BW*k +: DATA_BW];
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_row_d = rd_row_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = READ;
          rd_row_d = '0;
        end
      end
      READ: begin
        if (issue) begin
          if (rd_row_q == ROW_W'(N_LANE - 1)) begin
            state_d = DRAIN;
          end else begin
            rd_row_d = rd_row_q + ROW_W'(1);
          end
        end
      end
      DRAIN: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rd_row_q   <= '0;
      inflight_q <= 1'b0;
      infl_row_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_row_q   <= rd_row_d;
      inflight_q <= issue;
      if (issue) begin
        infl_row_q <= rd_row_q;
      end
    end
  end

  row_skid_fifo #(
    .DATA_BW (DATA_BW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rstn),
    .push_i     (inflight_q),
    .push_idx_i (infl_row_q),
    .push_row_i (cap_row),
    .pop_i      (pop),
    .head_idx_o (out_row_idx),
    .head_row_o (out_row),
    .count_o    (fifo_cnt),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_last  = out_valid
                  && (out_row_idx == ROW_W'(N_LANE - 1));

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rstn)
    !(inflight_q && fifo_full && !pop)
  );

endmodule
